// File: rtl/mc_controller.sv
// -----------------------------------------------------------------------------
// mc_controller
//   Multicycle main control FSM for the MIPS core. Steps each instruction
//   through fetch, decode, execute, memory and writeback. It drives the
//   datapath mux and enable controls and the 3-bit aluop used by aludec.
//   Memory states wait for mem_ready. An illegal opcode or a memory wait
//   longer than TIMEOUT_CYCLES cycles puts the FSM in a sticky FAULT state.
//
// Parameters
//   TIMEOUT_CYCLES  max cycles a memory state waits for mem_ready (>= 2)
//
// Ports
//   clk        in   1  clock, rising edge
//   reset      in   1  asynchronous, active-low reset
//   op         in   6  opcode from the instruction register
//   mem_ready  in   1  memory completed the current access this cycle
//   mem_req    out  1  memory access request
//   memwrite   out  1  memory write strobe
//   iord       out  1  0: address = PC, 1: address = ALUOut
//   irwrite    out  1  instruction register load
//   pcwrite    out  1  unconditional PC load
//   branch     out  1  conditional PC load (ANDed with zero in datapath)
//   pcsrc      out  2  00 ALU result, 01 ALUOut, 10 jump target
//   alusrca    out  1  0: PC, 1: rs
//   alusrcb    out  2  00 rt, 01 const 4, 10 signimm, 11 signimm<<2
//   aluop      out  3  000 add,001 sub,010 rtype,011 and,100 or,101 slt,110 dadd
//   regdst     out  1  0: rt, 1: rd
//   memtoreg   out  1  0: ALUOut, 1: memory data
//   regwrite   out  1  register file write enable
//   fault      out  1  sticky error flag
//   state      out  4  current state encoding (debug)
// -----------------------------------------------------------------------------
module mc_controller #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       memwrite,
  output logic       iord,
  output logic       irwrite,
  output logic       pcwrite,
  output logic       branch,
  output logic [1:0] pcsrc,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [2:0] aluop,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       fault,
  output logic [3:0] state
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_RTEX   = 4'd6,
    S_RTWB   = 4'd7,
    S_BEQEX  = 4'd8,
    S_IMMEX  = 4'd9,
    S_IMMWB  = 4'd10,
    S_JEX    = 4'd11,
    S_FAULT  = 4'd15
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       imm_aluop_q, imm_aluop_d;
  logic             wait_st;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_FETCH;
      cnt_q       <= '0;
      imm_aluop_q <= 3'b000;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      imm_aluop_q <= imm_aluop_d;
    end
  end

  assign state = state_q;

  always_comb begin
    state_d     = state_q;
    imm_aluop_d = imm_aluop_q;
    wait_st     = 1'b0;
    mem_req     = 1'b0;
    memwrite    = 1'b0;
    iord        = 1'b0;
    irwrite     = 1'b0;
    pcwrite     = 1'b0;
    branch      = 1'b0;
    pcsrc       = 2'b00;
    alusrca     = 1'b0;
    alusrcb     = 2'b00;
    aluop       = 3'b000;
    regdst      = 1'b0;
    memtoreg    = 1'b0;
    regwrite    = 1'b0;
    fault       = 1'b0;

    case (state_q)
      S_FETCH: begin
        wait_st = 1'b1;
        mem_req = 1'b1;
        alusrcb = 2'b01;
        // IR and PC load in the same cycle the fetch data arrives.
        irwrite = mem_ready;
        pcwrite = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        // Precompute the branch target (PC+4 + signimm<<2) while decoding.
        alusrcb = 2'b11;
        case (op)
          6'b100011, 6'b101011,
          6'b110111, 6'b111111: state_d = S_MEMADR;
          6'b000000:            state_d = S_RTEX;
          6'b000100:            state_d = S_BEQEX;
          6'b001000: begin state_d = S_IMMEX; imm_aluop_d = 3'b000; end
          6'b001100: begin state_d = S_IMMEX; imm_aluop_d = 3'b011; end
          6'b001101: begin state_d = S_IMMEX; imm_aluop_d = 3'b100; end
          6'b001010: begin state_d = S_IMMEX; imm_aluop_d = 3'b101; end
          6'b011000: begin state_d = S_IMMEX; imm_aluop_d = 3'b110; end
          6'b000010:            state_d = S_JEX;
          default:              state_d = S_FAULT;
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        if (op == 6'b100011 || op == 6'b110111) state_d = S_MEMRD;
        else                                      state_d = S_MEMWR;
      end
      S_MEMRD: begin
        wait_st = 1'b1;
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMWR: begin
        wait_st  = 1'b1;
        mem_req  = 1'b1;
        iord     = 1'b1;
        memwrite = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_RTEX: begin
        alusrca = 1'b1;
        aluop   = 3'b010;
        state_d = S_RTWB;
      end
      S_RTWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_BEQEX: begin
        alusrca = 1'b1;
        aluop   = 3'b001;
        branch  = 1'b1;
        pcsrc   = 2'b01;
        state_d = S_FETCH;
      end
      S_IMMEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        aluop   = imm_aluop_q;
        state_d = S_IMMWB;
      end
      S_IMMWB: begin
        regwrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_JEX: begin
        pcwrite = 1'b1;
        pcsrc   = 2'b10;
        state_d = S_FETCH;
      end
      S_FAULT: begin
        fault = 1'b1;
      end
      // Unused encodings are treated as corruption and trapped.
      default: state_d = S_FAULT;
    endcase

    // A late mem_ready on the final allowed cycle still wins over the timeout.
    if (wait_st && !mem_ready && cnt_q == CNT_LAST) state_d = S_FAULT;

    if (state_d != state_q)                            cnt_d = '0;
    else if (wait_st && !mem_ready && cnt_q != CNT_LAST) cnt_d = cnt_q + 1'b1;
    else                                                cnt_d = cnt_q;
  end

endmodule

// File: tb/tb_mc_controller.sv
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] op = 6'b000000;
  logic       mem_ready = 1'b0;
  logic       mem_req, memwrite, iord, irwrite, pcwrite, branch;
  logic [1:0] pcsrc, alusrcb;
  logic       alusrca, regdst, memtoreg, regwrite, fault;
  logic [2:0] aluop;
  logic [3:0] state;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mc_controller #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
    .mem_req(mem_req), .memwrite(memwrite), .iord(iord), .irwrite(irwrite),
    .pcwrite(pcwrite), .branch(branch), .pcsrc(pcsrc), .alusrca(alusrca),
    .alusrcb(alusrcb), .aluop(aluop), .regdst(regdst), .memtoreg(memtoreg),
    .regwrite(regwrite), .fault(fault), .state(state)
  );

  // Control bundle, MSB first:
  // mem_req memwrite iord irwrite pcwrite branch pcsrc[2] alusrca alusrcb[2]
  // aluop[3] regdst memtoreg regwrite fault
  logic [17:0] obs_ctl;
  assign obs_ctl = {mem_req, memwrite, iord, irwrite, pcwrite, branch, pcsrc,
                    alusrca, alusrcb, aluop, regdst, memtoreg, regwrite, fault};

  localparam logic [17:0] C_F_NR   = 18'b1_0_0_0_0_0_00_0_01_000_0_0_0_0;
  localparam logic [17:0] C_F_R    = 18'b1_0_0_1_1_0_00_0_01_000_0_0_0_0;
  localparam logic [17:0] C_DEC    = 18'b0_0_0_0_0_0_00_0_11_000_0_0_0_0;
  localparam logic [17:0] C_MEMADR = 18'b0_0_0_0_0_0_00_1_10_000_0_0_0_0;
  localparam logic [17:0] C_MEMRD  = 18'b1_0_1_0_0_0_00_0_00_000_0_0_0_0;
  localparam logic [17:0] C_MEMWB  = 18'b0_0_0_0_0_0_00_0_00_000_0_1_1_0;
  localparam logic [17:0] C_MEMWR  = 18'b1_1_1_0_0_0_00_0_00_000_0_0_0_0;
  localparam logic [17:0] C_RTEX   = 18'b0_0_0_0_0_0_00_1_00_010_0_0_0_0;
  localparam logic [17:0] C_RTWB   = 18'b0_0_0_0_0_0_00_0_00_000_1_0_1_0;
  localparam logic [17:0] C_BEQ    = 18'b0_0_0_0_0_1_01_1_00_001_0_0_0_0;
  localparam logic [17:0] C_IMMEX  = 18'b0_0_0_0_0_0_00_1_10_000_0_0_0_0;
  localparam logic [17:0] C_IMMWB  = 18'b0_0_0_0_0_0_00_0_00_000_0_0_1_0;
  localparam logic [17:0] C_JEX    = 18'b0_0_1_0_1_0_10_0_00_000_0_0_0_0 & 18'b1_1_0_1_1_1_11_1_11_111_1_1_1_1;
  localparam logic [17:0] C_FAULT  = 18'b0_0_0_0_0_0_00_0_00_000_0_0_0_1;

  typedef struct {
    logic        mr;
    logic [5:0]  op;
    logic [3:0]  st;
    logic [17:0] ctl;
  } step_t;

  typedef struct {
    logic [3:0]  st;
    logic [17:0] ctl;
  } exp_t;

  step_t steps[$];
  exp_t  exp_q[$];

  task automatic add(input logic mr, input logic [5:0] o, input logic [3:0] s,
                     input logic [17:0] c);
    step_t t;
    t.mr = mr; t.op = o; t.st = s; t.ctl = c;
    steps.push_back(t);
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic test_reset();
    exp_t e;
    reset = 1'b0;
    mem_ready = 1'b0;
    #1;
    checks++;
    if (state !== 4'd0 || obs_ctl !== C_F_NR) begin
      errors++;
      $display("FAIL reset_state: state=%0d ctl=%b, expected state=0 ctl=%b", state, obs_ctl, C_F_NR);
    end
    mem_ready = 1'b1;
    #1;
    checks++;
    if (obs_ctl !== C_F_R) begin
      errors++;
      $display("FAIL reset_mealy: ctl=%b, expected %b", obs_ctl, C_F_R);
    end
    apply_reset();
    // Walk into RTEX then abort with an asynchronous reset.
    add(1'b1, 6'b000000, 4'd0, C_F_R);
    add(1'b0, 6'b000000, 4'd1, C_DEC);
    add(1'b0, 6'b000000, 4'd6, C_RTEX);
    foreach (steps[i]) begin
      op = steps[i].op; mem_ready = steps[i].mr;
      e.st = steps[i].st; e.ctl = steps[i].ctl;
      exp_q.push_back(e);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (state !== e.st || obs_ctl !== e.ctl) begin
        errors++;
        $display("FAIL reset_walk step %0d: state=%0d ctl=%b, expected state=%0d ctl=%b", i, state, obs_ctl, e.st, e.ctl);
      end
      if (i < steps.size() - 1) begin
        @(posedge clk); #1;
      end
    end
    steps.delete();
    #1 reset = 1'b0;
    #1;
    checks++;
    if (state !== 4'd0 || regwrite !== 1'b0) begin
      errors++;
      $display("FAIL reset_abort: state=%0d regwrite=%b, expected state=0 regwrite=0", state, regwrite);
    end
  endtask

  task automatic test_rtype();
    exp_t e;
    apply_reset();
    add(1'b1, 6'b000000, 4'd0, C_F_R);
    add(1'b1, 6'b000000, 4'd1, C_DEC);
    add(1'b1, 6'b000000, 4'd6, C_RTEX);
    add(1'b1, 6'b000000, 4'd7, C_RTWB);
    add(1'b0, 6'b000000, 4'd0, C_F_NR);
    foreach (steps[i]) begin
      op = steps[i].op; mem_ready = steps[i].mr;
      e.st = steps[i].st; e.ctl = steps[i].ctl;
      exp_q.push_back(e);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (state !== e.st || obs_ctl !== e.ctl) begin
        errors++;
        $display("FAIL rtype step %0d: state=%0d ctl=%b, expected state=%0d ctl=%b", i, state, obs_ctl, e.st, e.ctl);
      end
      @(posedge clk); #1;
    end
    steps.delete();
  endtask

  task automatic test_memory();
    exp_t e;
    // lw with a three-cycle stall in MEMRD
    apply_reset();
    add(1'b1, 6'b100011, 4'd0, C_F_R);
    add(1'b0, 6'b100011, 4'd1, C_DEC);
    add(1'b1, 6'b100011, 4'd2, C_MEMADR);
    add(1'b0, 6'b100011, 4'd3, C_MEMRD);
    add(1'b0, 6'b100011, 4'd3, C_MEMRD);
    add(1'b0, 6'b100011, 4'd3, C_MEMRD);
    add(1'b1, 6'b100011, 4'd3, C_MEMRD);
    add(1'b0, 6'b100011, 4'd4, C_MEMWB);
    add(1'b0, 6'b100011, 4'd0, C_F_NR);
    // ld
    add(1'b1, 6'b110111, 4'd0, C_F_R);
    add(1'b1, 6'b110111, 4'd1, C_DEC);
    add(1'b1, 6'b110111, 4'd2, C_MEMADR);
    add(1'b1, 6'b110111, 4'd3, C_MEMRD);
    add(1'b1, 6'b110111, 4'd4, C_MEMWB);
    // sw
    add(1'b1, 6'b101011, 4'd0, C_F_R);
    add(1'b1, 6'b101011, 4'd1, C_DEC);
    add(1'b1, 6'b101011, 4'd2, C_MEMADR);
    add(1'b1, 6'b101011, 4'd5, C_MEMWR);
    // sd with one stall
    add(1'b1, 6'b111111, 4'd0, C_F_R);
    add(1'b1, 6'b111111, 4'd1, C_DEC);
    add(1'b1, 6'b111111, 4'd2, C_MEMADR);
    add(1'b0, 6'b111111, 4'd5, C_MEMWR);
    add(1'b1, 6'b111111, 4'd5, C_MEMWR);
    add(1'b0, 6'b111111, 4'd0, C_F_NR);
    foreach (steps[i]) begin
      op = steps[i].op; mem_ready = steps[i].mr;
      e.st = steps[i].st; e.ctl = steps[i].ctl;
      exp_q.push_back(e);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (state !== e.st || obs_ctl !== e.ctl) begin
        errors++;
        $display("FAIL memory step %0d: state=%0d ctl=%b, expected state=%0d ctl=%b", i, state, obs_ctl, e.st, e.ctl);
      end
      @(posedge clk); #1;
    end
    steps.delete();
  endtask

  task automatic test_immediate();
    exp_t e;
    logic [5:0] ops[5]  = '{6'b001000, 6'b001100, 6'b001101, 6'b001010, 6'b011000};
    logic [2:0] alus[5] = '{3'b000, 3'b011, 3'b100, 3'b101, 3'b110};
    apply_reset();
    for (int k = 0; k < 5; k++) begin
      add(1'b1, ops[k], 4'd0, C_F_R);
      add(1'b1, ops[k], 4'd1, C_DEC);
      add(1'b1, ops[k], 4'd9, C_IMMEX | {11'b0, alus[k], 4'b0});
      add(1'b1, ops[k], 4'd10, C_IMMWB);
    end
    foreach (steps[i]) begin
      op = steps[i].op; mem_ready = steps[i].mr;
      e.st = steps[i].st; e.ctl = steps[i].ctl;
      exp_q.push_back(e);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (state !== e.st || obs_ctl !== e.ctl) begin
        errors++;
        $display("FAIL immediate step %0d: state=%0d ctl=%b, expected state=%0d ctl=%b", i, state, obs_ctl, e.st, e.ctl);
      end
      @(posedge clk); #1;
    end
    steps.delete();
  endtask

  task automatic test_branch_jump();
    exp_t e;
    apply_reset();
    add(1'b1, 6'b000100, 4'd0, C_F_R);
    add(1'b1, 6'b000100, 4'd1, C_DEC);
    add(1'b1, 6'b000100, 4'd8, C_BEQ);
    add(1'b1, 6'b000010, 4'd0, C_F_R);
    add(1'b1, 6'b000010, 4'd1, C_DEC);
    add(1'b1, 6'b000010, 4'd11, C_JEX);
    add(1'b0, 6'b000010, 4'd0, C_F_NR);
    foreach (steps[i]) begin
      op = steps[i].op; mem_ready = steps[i].mr;
      e.st = steps[i].st; e.ctl = steps[i].ctl;
      exp_q.push_back(e);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (state !== e.st || obs_ctl !== e.ctl) begin
        errors++;
        $display("FAIL branch_jump step %0d: state=%0d ctl=%b, expected state=%0d ctl=%b", i, state, obs_ctl, e.st, e.ctl);
      end
      @(posedge clk); #1;
    end
    steps.delete();
  endtask

  task automatic test_illegal();
    exp_t e;
    apply_reset();
    add(1'b1, 6'b111000, 4'd0, C_F_R);
    add(1'b1, 6'b111000, 4'd1, C_DEC);
    for (int k = 0; k < 20; k++)
      add(1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), 4'd15, C_FAULT);
    foreach (steps[i]) begin
      op = steps[i].op; mem_ready = steps[i].mr;
      e.st = steps[i].st; e.ctl = steps[i].ctl;
      exp_q.push_back(e);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (state !== e.st || obs_ctl !== e.ctl) begin
        errors++;
        $display("FAIL illegal step %0d: state=%0d ctl=%b, expected state=%0d ctl=%b", i, state, obs_ctl, e.st, e.ctl);
      end
      @(posedge clk); #1;
    end
    steps.delete();
    mem_ready = 1'b0;
    reset = 1'b0;
    #1;
    checks++;
    if (state !== 4'd0 || fault !== 1'b0) begin
      errors++;
      $display("FAIL illegal_clear: state=%0d fault=%b, expected state=0 fault=0", state, fault);
    end
  endtask

  task automatic test_timeout();
    exp_t e;
    int   n;
    // 16 idle fetch cycles -> FAULT
    apply_reset();
    for (int k = 0; k < 16; k++) add(1'b0, 6'b000000, 4'd0, C_F_NR);
    add(1'b0, 6'b000000, 4'd15, C_FAULT);
    n = steps.size();
    // Ready on the last allowed cycle wins
    for (int k = 0; k < 15; k++) add(1'b0, 6'b000000, 4'd0, C_F_NR);
    add(1'b1, 6'b000000, 4'd0, C_F_R);
    add(1'b0, 6'b000000, 4'd1, C_DEC);
    // MEMWR timeout
    add(1'b1, 6'b101011, 4'd0, C_F_R);
    add(1'b1, 6'b101011, 4'd1, C_DEC);
    add(1'b1, 6'b101011, 4'd2, C_MEMADR);
    for (int k = 0; k < 16; k++) add(1'b0, 6'b101011, 4'd5, C_MEMWR);
    add(1'b0, 6'b101011, 4'd15, C_FAULT);
    foreach (steps[i]) begin
      if (i == n || i == n + 17) apply_reset();
      op = steps[i].op; mem_ready = steps[i].mr;
      e.st = steps[i].st; e.ctl = steps[i].ctl;
      exp_q.push_back(e);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (state !== e.st || obs_ctl !== e.ctl) begin
        errors++;
        $display("FAIL timeout step %0d: state=%0d ctl=%b, expected state=%0d ctl=%b", i, state, obs_ctl, e.st, e.ctl);
      end
      @(posedge clk); #1;
    end
    steps.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_rtype();
    test_memory();
    test_immediate();
    test_branch_jump();
    test_illegal();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
